// File: rtl/bmd_rd_pkg.sv
// rtl/bmd_rd_pkg.sv - shared states, error bit indices and length decode for the MRd credit throttle
package bmd_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10,
        ST_ERR   = 2'b11
    } rd_state_t;

    localparam int ERR_CPL = 0;
    localparam int ERR_TMO = 1;

    // PCIe length field: 0 means 1024 DWs
    function automatic logic [11:0] len_decode(input logic [10:0] len);
        return (len == 11'd0) ? 12'd1024 : {1'b0, len};
    endfunction

endpackage

// File: rtl/bmd_rd_tmo_cnt.sv
// rtl/bmd_rd_tmo_cnt.sv - completion timeout counter with clear, enable and one-cycle expire pulse
module bmd_rd_tmo_cnt #(
    parameter int             W     = 20,
    parameter logic [W-1:0]   LIMIT = {W{1'b1}}
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && cnt != LIMIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    // fires on the cycle the count would reach LIMIT
    assign expire = en & ~clr & (cnt == LIMIT - 1'b1);

endmodule

// File: rtl/bmd_rd_credit_throttle.sv
// rtl/bmd_rd_credit_throttle.sv - MRd request/DW credit throttle; optional high-water marks via BMD_RD_THROTTLE_HWM_EN
module bmd_rd_credit_throttle
    import bmd_rd_pkg::*;
#(
    parameter int                 MAX_REQ = 8,
    parameter int                 DW_W    = 16,
    parameter int                 TMO_W   = 20,
    parameter logic [TMO_W-1:0]   TMO_CYC = 20'hF_FFFF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            init_rst_i,
    input  logic            rd_metering_i,
    input  logic [7:0]      req_limit_i,
    input  logic [DW_W-1:0] dw_limit_i,
    input  logic            mrd_work_i,
    input  logic [10:0]     mrd_len_i,
    input  logic            mrd_sent_i,
    input  logic            cpld_vld_i,
    input  logic [10:0]     cpld_len_i,
    input  logic            cpld_last_i,
    input  logic            cpld_err_i,
`ifdef BMD_RD_THROTTLE_HWM_EN
    output logic [7:0]      hwm_req_o,
    output logic [DW_W-1:0] hwm_dw_o,
`endif
    output logic            mrd_work_o,
    output logic [7:0]      outst_req_o,
    output logic [DW_W-1:0] outst_dw_o,
    output logic [1:0]      state_o,
    output logic [1:0]      err_o
);

    localparam int CW = DW_W + 2;

    rd_state_t       state_q, state_nx;
    logic [7:0]      req_q, req_nx, eff_lim;
    logic [DW_W-1:0] dw_q, dw_nx;
    logic [1:0]      err_q, err_nx;
    logic            work_q, work_nx;
    logic [CW-1:0]   mrd_len, cpl_len, dw_sum, dw_diff;
    logic [DW_W:0]   dw_chk;
    logic            udf, ovf, err_evt, tmo_exp, cpl_done;

    assign mrd_len  = CW'(len_decode(mrd_len_i));
    assign cpl_len  = CW'(len_decode(cpld_len_i));
    assign cpl_done = cpld_vld_i & cpld_last_i;

    always_comb begin
        eff_lim = (req_limit_i > 8'(MAX_REQ)) ? 8'(MAX_REQ) : req_limit_i;
        if (eff_lim == 8'd0) eff_lim = 8'd1;
    end

    always_comb begin
        req_nx  = req_q;
        dw_nx   = dw_q;
        udf     = 1'b0;
        ovf     = 1'b0;
        dw_diff = '0;
        dw_sum  = {2'b00, dw_q} + (mrd_sent_i ? mrd_len : '0);
        if (mrd_sent_i && !cpl_done) begin
            if (req_q == 8'hFF) ovf = 1'b1;
            else                req_nx = req_q + 8'd1;
        end else if (!mrd_sent_i && cpl_done) begin
            if (req_q == 8'd0) udf = 1'b1;
            else               req_nx = req_q - 8'd1;
        end
        if (cpld_vld_i && dw_sum < cpl_len) begin
            udf   = 1'b1;
            dw_nx = '0;
        end else begin
            dw_diff = dw_sum - (cpld_vld_i ? cpl_len : '0);
            if (dw_diff > {2'b00, {DW_W{1'b1}}}) begin
                ovf   = 1'b1;
                dw_nx = '1;
            end else begin
                dw_nx = dw_diff[DW_W-1:0];
            end
        end
        if (state_q == ST_ERR) begin
            req_nx = req_q;
            dw_nx  = dw_q;
        end
    end

    assign err_evt = udf | cpld_err_i | tmo_exp;

    always_comb begin
        err_nx = err_q;
        if (udf | ovf | cpld_err_i) err_nx[ERR_CPL] = 1'b1;
        if (tmo_exp)                err_nx[ERR_TMO] = 1'b1;
    end

    always_comb begin
        state_nx = state_q;
        case (state_q)
            ST_IDLE:  if (mrd_work_i) state_nx = ST_RUN;
            ST_RUN:   if (!mrd_work_i) state_nx = (req_q != 8'd0) ? ST_DRAIN : ST_IDLE;
            ST_DRAIN: begin
                if (mrd_work_i)          state_nx = ST_RUN;
                else if (req_q == 8'd0)  state_nx = ST_IDLE;
            end
            default:  state_nx = ST_ERR;
        endcase
        if (err_evt) state_nx = ST_ERR;
    end

    // credit check on next-state counters, one bit wider so the sum cannot wrap
    assign dw_chk  = {1'b0, dw_nx} + mrd_len[DW_W:0];
    assign work_nx = mrd_work_i && (state_nx == ST_RUN) && (req_nx < eff_lim)
                     && (dw_chk <= {1'b0, dw_limit_i});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            dw_q    <= '0;
            err_q   <= '0;
            work_q  <= 1'b0;
        end else if (init_rst_i) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            dw_q    <= '0;
            err_q   <= '0;
            work_q  <= 1'b0;
        end else begin
            state_q <= state_nx;
            req_q   <= req_nx;
            dw_q    <= dw_nx;
            err_q   <= err_nx;
            work_q  <= work_nx;
        end
    end

    bmd_rd_tmo_cnt #(
        .W     (TMO_W),
        .LIMIT (TMO_CYC)
    ) u_tmo (
        .clk    (clk),
        .rst    (rst),
        .clr    (init_rst_i | cpld_vld_i | (req_q == 8'd0)),
        .en     ((req_q != 8'd0) & (state_q != ST_ERR)),
        .expire (tmo_exp)
    );

`ifdef BMD_RD_THROTTLE_HWM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hwm_req_o <= '0;
            hwm_dw_o  <= '0;
        end else if (init_rst_i) begin
            hwm_req_o <= '0;
            hwm_dw_o  <= '0;
        end else begin
            if (req_q > hwm_req_o) hwm_req_o <= req_q;
            if (dw_q > hwm_dw_o)   hwm_dw_o  <= dw_q;
        end
    end
`endif

    assign mrd_work_o  = (state_q == ST_ERR) ? 1'b0 : (rd_metering_i ? work_q : mrd_work_i);
    assign outst_req_o = req_q;
    assign outst_dw_o  = dw_q;
    assign state_o     = state_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_bmd_rd_credit_throttle.sv
// tb/tb_bmd_rd_credit_throttle.sv - scoreboard bench for the MRd credit throttle
module tb_bmd_rd_credit_throttle;

    logic        clk = 1'b0;
    logic        rst, init_rst_i, rd_metering_i;
    logic [7:0]  req_limit_i;
    logic [15:0] dw_limit_i;
    logic        mrd_work_i, mrd_sent_i, cpld_vld_i, cpld_last_i, cpld_err_i;
    logic [10:0] mrd_len_i, cpld_len_i;
    logic        mrd_work_o;
    logic [7:0]  outst_req_o;
    logic [15:0] outst_dw_o;
    logic [1:0]  state_o, err_o;
`ifdef BMD_RD_THROTTLE_HWM_EN
    logic [7:0]  hwm_req_o;
    logic [15:0] hwm_dw_o;
`endif

    always #5 clk = ~clk;

    bmd_rd_credit_throttle #(
        .MAX_REQ (8),
        .DW_W    (16),
        .TMO_W   (20),
        .TMO_CYC (20'd100)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .init_rst_i    (init_rst_i),
        .rd_metering_i (rd_metering_i),
        .req_limit_i   (req_limit_i),
        .dw_limit_i    (dw_limit_i),
        .mrd_work_i    (mrd_work_i),
        .mrd_len_i     (mrd_len_i),
        .mrd_sent_i    (mrd_sent_i),
        .cpld_vld_i    (cpld_vld_i),
        .cpld_len_i    (cpld_len_i),
        .cpld_last_i   (cpld_last_i),
        .cpld_err_i    (cpld_err_i),
`ifdef BMD_RD_THROTTLE_HWM_EN
        .hwm_req_o     (hwm_req_o),
        .hwm_dw_o      (hwm_dw_o),
`endif
        .mrd_work_o    (mrd_work_o),
        .outst_req_o   (outst_req_o),
        .outst_dw_o    (outst_dw_o),
        .state_o       (state_o),
        .err_o         (err_o)
    );

    typedef struct {
        string tag;
        int    req;
        int    dw;
        int    work;
        int    st;
        int    err;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, ".req"},   32'(outst_req_o), 32'(e.req));
            check({e.tag, ".dw"},    32'(outst_dw_o),  32'(e.dw));
            check({e.tag, ".work"},  32'(mrd_work_o),  32'(e.work));
            check({e.tag, ".state"}, 32'(state_o),     32'(e.st));
            check({e.tag, ".err"},   32'(err_o),       32'(e.err));
        end
    end

    // inputs are already set; expectation applies after the coming edge
    task automatic step(input string tag, input int req, input int dw, input int work,
                        input int st, input int err);
        exp_t x;
        x.tag = tag; x.req = req; x.dw = dw; x.work = work; x.st = st; x.err = err;
        sb.push_back(x);
        @(negedge clk);
        mrd_sent_i  = 1'b0;
        cpld_vld_i  = 1'b0;
        cpld_last_i = 1'b0;
        cpld_err_i  = 1'b0;
        init_rst_i  = 1'b0;
    endtask

    task automatic soft_reset(input string tag);
        init_rst_i = 1'b1;
        mrd_work_i = 1'b0;
        step(tag, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; init_rst_i = 1'b0; rd_metering_i = 1'b1;
        req_limit_i = 8'd4; dw_limit_i = 16'd4096;
        mrd_work_i = 1'b0; mrd_len_i = 11'd32; mrd_sent_i = 1'b0;
        cpld_vld_i = 1'b0; cpld_len_i = 11'd0; cpld_last_i = 1'b0; cpld_err_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        step("reset", 0, 0, 0, 0, 0);

        // request limit 4
        mrd_work_i = 1'b1;
        step("lim_run", 0, 0, 1, 1, 0);
        for (int i = 1; i <= 4; i++) begin
            mrd_sent_i = 1'b1;
            step($sformatf("lim_send%0d", i), i, 32 * i, (i < 4) ? 1 : 0, 1, 0);
        end
        cpld_vld_i = 1'b1; cpld_last_i = 1'b1; cpld_len_i = 11'd32;
        step("lim_cpl", 3, 96, 1, 1, 0);

        // DW limit 100
        soft_reset("init1");
        req_limit_i = 8'd8; dw_limit_i = 16'd100; mrd_work_i = 1'b1;
        step("dw_run", 0, 0, 1, 1, 0);
        for (int i = 1; i <= 3; i++) begin
            mrd_sent_i = 1'b1;
            step($sformatf("dw_send%0d", i), i, 32 * i, (i < 3) ? 1 : 0, 1, 0);
        end
        cpld_vld_i = 1'b1; cpld_len_i = 11'd16;
        step("dw_p16a", 3, 80, 0, 1, 0);
        cpld_vld_i = 1'b1; cpld_len_i = 11'd16;
        step("dw_p16b", 3, 64, 1, 1, 0);
        cpld_vld_i = 1'b1; cpld_len_i = 11'd15;
        step("dw_p15", 3, 49, 1, 1, 0);

        // length 0 encodes 1024
        soft_reset("init2");
        dw_limit_i = 16'd1024; mrd_len_i = 11'd0; mrd_work_i = 1'b1;
        step("l0_run", 0, 0, 1, 1, 0);
        mrd_sent_i = 1'b1;
        step("l0_send", 1, 1024, 0, 1, 0);
        cpld_vld_i = 1'b1; cpld_last_i = 1'b1; cpld_len_i = 11'd0;
        step("l0_cpl", 0, 0, 1, 1, 0);

        // simultaneous send and final completion
        soft_reset("init3");
        dw_limit_i = 16'd4096; mrd_len_i = 11'd16; mrd_work_i = 1'b1;
        step("sim_run", 0, 0, 1, 1, 0);
        mrd_sent_i = 1'b1;
        step("sim_send", 1, 16, 1, 1, 0);
        mrd_sent_i = 1'b1; cpld_vld_i = 1'b1; cpld_last_i = 1'b1; cpld_len_i = 11'd16;
        step("sim_both", 1, 16, 1, 1, 0);

        // underflow, ERR gating, soft reset out of ERR
        soft_reset("init4");
        mrd_work_i = 1'b1; cpld_vld_i = 1'b1; cpld_last_i = 1'b1; cpld_len_i = 11'd4;
        step("udf", 0, 0, 0, 3, 1);
        rd_metering_i = 1'b0;
        step("err_bypass", 0, 0, 0, 3, 1);
        soft_reset("init5");

        // bypass ignores limits; completion error
        dw_limit_i = 16'd0; mrd_work_i = 1'b1;
        step("byp_run", 0, 0, 1, 1, 0);
        cpld_err_i = 1'b1;
        step("cpl_err", 0, 0, 0, 3, 1);
        soft_reset("init6");
        rd_metering_i = 1'b1; dw_limit_i = 16'd4096; req_limit_i = 8'd1; mrd_len_i = 11'd32;

        // timeout after 100 silent cycles
        mrd_work_i = 1'b1;
        step("tmo_run", 0, 0, 1, 1, 0);
        mrd_sent_i = 1'b1;
        step("tmo_send", 1, 32, 0, 1, 0);
        repeat (98) @(negedge clk);
        step("tmo_c99", 1, 32, 0, 1, 0);
        step("tmo_c100", 1, 32, 0, 3, 2);

        // completion at cycle 99 restarts the count
        soft_reset("init7");
        mrd_work_i = 1'b1;
        step("tmo2_run", 0, 0, 1, 1, 0);
        mrd_sent_i = 1'b1;
        step("tmo2_send", 1, 32, 0, 1, 0);
        repeat (98) @(negedge clk);
        cpld_vld_i = 1'b1; cpld_len_i = 11'd1;
        step("tmo2_c99", 1, 31, 0, 1, 0);
        step("tmo2_c100", 1, 31, 0, 1, 0);
        repeat (98) @(negedge clk);
        step("tmo2_c199", 1, 31, 0, 3, 2);

        soft_reset("final");
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bmd_rd_credit_throttle.md
Name: bmd_rd_credit_throttle

Overview:
- Parametrised successor to the DMA read metering unit in the PCI-Express Bus Master DMA path.
- Counts outstanding MRd requests and outstanding completion DWs against programmable limits.
- Gates the Tx engine's MRd strobe so the completion buffer cannot overflow.
- Adds a completion timeout and error/drain states.
- Sits between the DMA control registers, the Tx MRd engine and the Rx completion parser.

Parameters:
- MAX_REQ, 8: hard ceiling on outstanding MRd requests; 1..255.
- DW_W, 16: width of the outstanding-DW counter and of the limit.
- TMO_W, 20: width of the completion-timeout counter.
- TMO_CYC, 20'hF_FFFF: cycles without any completion while requests are outstanding before timeout.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset. The block has one clock; reset is asynchronous and active-high.
- init_rst_i  in  1  synchronous soft reset from the DMA control register.
- rd_metering_i  in  1  1 = throttle active; 0 = bypass.
- req_limit_i  in  8  runtime request limit; the effective limit is min(req_limit_i, MAX_REQ); 0 is treated as 1.
- dw_limit_i  in  DW_W  runtime outstanding-DW limit.
- mrd_work_i  in  1  Tx engine wants to issue an MRd.
- mrd_len_i  in  11  length of the next MRd in DWs; 0 encodes 1024.
- mrd_sent_i  in  1  pulse: one MRd of mrd_len_i DWs was issued this cycle.
- cpld_vld_i  in  1  pulse: one completion TLP received.
- cpld_len_i  in  11  DW payload of that completion; 0 encodes 1024.
- cpld_last_i  in  1  qualifies cpld_vld_i: final completion of its request.
- cpld_err_i  in  1  malformed completion, or completion with data error.
- mrd_work_o  out  1  gated MRd enable to the Tx engine.
- outst_req_o  out  8  outstanding request count.
- outst_dw_o  out  DW_W  outstanding completion DWs.
- state_o  out  2  00 IDLE, 01 RUN, 10 DRAIN, 11 ERR.
- err_o  out  2  sticky flags: bit0 completion error/underflow, bit1 timeout.

Behaviour:
- Reset values (rst or init_rst_i): counters 0, state IDLE, err_o 0, timeout counter 0, mrd_work_o 0. init_rst_i has priority over every other event in the same cycle.
- Length decode: an 11-bit length of 0 is treated as 1024. Lengths are zero-extended to DW_W before any arithmetic.
- IDLE -> RUN when mrd_work_i=1.
- RUN -> DRAIN when mrd_work_i falls while outst_req_o>0.
- RUN -> IDLE when mrd_work_i falls while outst_req_o=0.
- DRAIN -> IDLE when outst_req_o reaches 0.
- DRAIN -> RUN if mrd_work_i reasserts.
- Any state -> ERR on a completion error, an underflow or a timeout. ERR is left only through init_rst_i.
- Counter update, registered, 1-cycle latency:
  - outst_req += mrd_sent_i - (cpld_vld_i & cpld_last_i).
  - outst_dw += (mrd_sent_i ? len(mrd) : 0) - (cpld_vld_i ? len(cpld) : 0).
  - A send and a completion in the same cycle are applied together as one net update.
- Underflow: a completion that would drive either counter below 0 saturates that counter at 0, sets err_o[0] and enters ERR.
- Overflow is impossible by construction, because mrd_work_o holds the counters within the limits. An mrd_sent_i while mrd_work_o=0 is still counted; the counters saturate at their maximum and err_o[0] is set.
- mrd_work_o is registered and computed from next-state values, so a send in cycle N is reflected at N+1.
  - rd_metering_i=0: mrd_work_o = mrd_work_i, combinational bypass; counters and timeout still run.
  - rd_metering_i=1: mrd_work_o = mrd_work_i & state==RUN & outst_req < eff_req_limit & (outst_dw + len(mrd_len_i) <= dw_limit_i). The comparison is done at DW_W+1 bits so it cannot wrap.
- Timeout:
  - The counter increments each cycle while outst_req>0 and no cpld_vld_i.
  - It clears on cpld_vld_i or when outst_req=0.
  - Reaching TMO_CYC sets err_o[1] and enters ERR.
- ERR: mrd_work_o=0 regardless of rd_metering_i. Counters freeze.

Optional Feature:
- BMD_RD_THROTTLE_HWM_EN defined:
  - Adds outputs hwm_req_o[7:0] and hwm_dw_o[DW_W-1:0].
  - These hold the maximum outst_req and outst_dw values reached since the last reset or init_rst_i, updated one cycle after the counters.
- Undefined: the ports and the tracking registers are absent; all other behaviour is identical.

Decomposition:
- Package bmd_rd_pkg holds:
  - state enum constants ST_IDLE/ST_RUN/ST_DRAIN/ST_ERR;
  - err bit indices;
  - the len-decode function (0 -> 1024).
- One sub-module, bmd_rd_tmo_cnt: a parametrised timeout counter with clear, enable and expire pulse.

Test Plan:
- Limit test: rd_metering_i=1, req_limit_i=4, dw_limit_i=4096, mrd_len_i=32, four sends -> mrd_work_o=0 after the 4th send, outst_dw_o=128. One cpld_last with len 32 -> mrd_work_o=1 the next cycle.
- DW limit: req_limit_i=8, dw_limit_i=100, len=32 -> 3 sends allowed (96 DWs), 4th blocked. Three partial completions of 16, 16, 15 DWs without last -> outst_dw_o=49, outst_req_o=3.
- Length 0: mrd_len_i=0, dw_limit_i=1024 -> one send, outst_dw_o=1024, blocked. cpld_len 0 with last -> outst_dw_o=0, outst_req_o=0.
- Simultaneous: mrd_sent_i and cpld_vld_i+last in the same cycle with equal lengths 16 -> counters unchanged.
- Error paths:
  - cpld_vld_i with outst_req_o=0 -> err_o=01, state_o=11, mrd_work_o=0.
  - init_rst_i -> all outputs at reset values.
- Timeout: TMO_CYC=100, one send, no completions -> err_o[1] set on cycle 100 after the send; a completion at cycle 99 clears the counter instead.
